// File: rtl/road_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// road_sensor_conditioner
//
// Purpose:
//   Front end for the traffic light controller's secondary-road sensor.
//   It turns the raw, asynchronous vehicle sensor into a clean request that
//   is held until the controller grants secondary green. The path is:
//     raw sensor -> 2-flop synchronizer -> debounce filter
//     -> presence qualification FSM -> sticky request
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive disagreeing synced samples needed before
//                    sensorDebounced flips (>= 1)
//   PRESENCE_CYCLES  cycles sensorDebounced must stay high before a request
//                    is raised (>= 1)
//
// Ports:
//   clk                  in   system clock (10 MHz)
//   reset                in   synchronous, active-high reset
//   secondaryRoadSensor  in   raw asynchronous vehicle sensor
//   secondaryGreen       in   grant from controller (secondary green lamp)
//   sensorDebounced      out  filtered sensor level
//   vehicleRequest       out  qualified, held request to the controller
//   vehicleCount[15:0]   out  qualified-vehicle count, saturating
//                             (present only with SENSOR_STATS_EN defined)
//
// Build option:
//   SENSOR_STATS_EN  when defined, adds the vehicleCount port and counter.
// ---------------------------------------------------------------------------
module road_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int PRESENCE_CYCLES = 10000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        secondaryRoadSensor,
  input  logic        secondaryGreen,
  output logic        sensorDebounced,
  output logic        vehicleRequest
`ifdef SENSOR_STATS_EN
  ,
  output logic [15:0] vehicleCount
`endif
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PRESENCE_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);
  localparam logic [PW-1:0] PRES_MAX = PW'(PRESENCE_CYCLES);
  localparam logic [PW-1:0] PRES_ONE = PW'(1);

  typedef enum logic [1:0] {
    IDLE,
    QUALIFY,
    REQUEST,
    SERVED
  } state_t;

  // -------------------------------------------------------------------------
  // Synchronizer and debounce filter
  // -------------------------------------------------------------------------
  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          deb_q, deb_d;

  // The counter only runs while the synced sample disagrees with the
  // filtered level; any agreeing sample restarts it. The flip happens on the
  // edge where the count would reach DEBOUNCE_CYCLES, so comparing against
  // DEBOUNCE_CYCLES-1 keeps the counter from ever holding that value.
  always_comb begin
    s1_d      = secondaryRoadSensor;
    s2_d      = s1_q;
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    if (s2_q == deb_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_d     = s2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      deb_cnt_q <= '0;
      deb_q     <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      deb_cnt_q <= deb_cnt_d;
      deb_q     <= deb_d;
    end
  end

  assign sensorDebounced = deb_q;

  // -------------------------------------------------------------------------
  // Presence qualification FSM
  // -------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic          req_q, req_d;

  // Next-state logic. pc counts cycles of debounced presence; it is loaded
  // with 1 on entry to QUALIFY so that REQUEST is reached exactly
  // PRESENCE_CYCLES+1 edges after sensorDebounced rises. REQUEST is sticky
  // against the sensor: once qualified, the vehicle has been seen.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (deb_q) begin
          state_d = QUALIFY;
          pc_d    = PRES_ONE;
        end
      end
      QUALIFY: begin
        if (!deb_q) begin
          state_d = IDLE;
          pc_d    = '0;
        end else if (pc_q == PRES_MAX) begin
          state_d = REQUEST;
          pc_d    = '0;
        end else begin
          pc_d = pc_q + PRES_ONE;
        end
      end
      REQUEST: begin
        if (secondaryGreen) begin
          state_d = SERVED;
        end
      end
      SERVED: begin
        // A vehicle still present after green ends must requalify.
        if (!secondaryGreen) begin
          if (deb_q) begin
            state_d = QUALIFY;
            pc_d    = PRES_ONE;
          end else begin
            state_d = IDLE;
            pc_d    = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // Output logic. The request is registered from the next state so it
  // changes on the same edge as the state and is glitch-free.
  always_comb begin
    req_d = (state_d == REQUEST);
  end

`ifdef SENSOR_STATS_EN
  logic [15:0] count_q, count_d;

  // Count each completed qualification, saturating instead of wrapping.
  always_comb begin
    count_d = count_q;
    if ((state_q == QUALIFY) && (state_d == REQUEST) && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign vehicleCount = count_q;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
    end
  end

  assign vehicleRequest = req_q;

endmodule

// File: tb/tb_road_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// tb_road_sensor_conditioner
//
// Directed bench for road_sensor_conditioner with DEBOUNCE_CYCLES=4 and
// PRESENCE_CYCLES=8 on a 100 ns clock. Edge numbering in the comments is
// relative to the first rising edge that samples a new raw input level.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// ---------------------------------------------------------------------------
module tb_road_sensor_conditioner;

  localparam int DEB  = 4;
  localparam int PRES = 8;

  logic        clk;
  logic        reset;
  logic        secondaryRoadSensor;
  logic        secondaryGreen;
  logic        sensorDebounced;
  logic        vehicleRequest;
`ifdef SENSOR_STATS_EN
  logic [15:0] vehicleCount;
`endif

  int total;
  int bad;

  road_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .PRESENCE_CYCLES(PRES)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .secondaryRoadSensor (secondaryRoadSensor),
    .secondaryGreen      (secondaryGreen),
    .sensorDebounced     (sensorDebounced),
    .vehicleRequest      (vehicleRequest)
`ifdef SENSOR_STATS_EN
    ,
    .vehicleCount        (vehicleCount)
`endif
  );

  // 100 ns clock.
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Advance n rising edges, stopping 1 ns after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic sensor, input logic green);
    reset               = rst;
    secondaryRoadSensor = sensor;
    secondaryGreen      = green;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    applyStimulus(1'b1, 1'b1, 1'b0);

    // 1. Reset held for 3 cycles with the sensor high.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("reset_deb", {15'd0, sensorDebounced}, 16'd0);
      checkOutput("reset_req", {15'd0, vehicleRequest}, 16'd0);
`ifdef SENSOR_STATS_EN
      checkOutput("reset_count", vehicleCount, 16'd0);
`endif
    end
    // Release; E1 is the first edge that samples the sensor out of reset.
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(5);
    checkOutput("rel_deb_e5", {15'd0, sensorDebounced}, 16'd0);
    tick(1);
    checkOutput("rel_deb_e6", {15'd0, sensorDebounced}, 16'd1);
    // Drop the sensor early: presence lasts too short to raise a request.
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      tick(1);
      checkOutput("rel_req_low", {15'd0, vehicleRequest}, 16'd0);
    end
    checkOutput("rel_deb_fall", {15'd0, sensorDebounced}, 16'd0);

    // 2. Glitch: 3 cycles high only reaches a debounce count of 3.
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkOutput("glitch_deb", {15'd0, sensorDebounced}, 16'd0);
      checkOutput("glitch_req", {15'd0, vehicleRequest}, 16'd0);
    end

    // 3. Short presence: 8 raw cycles keep sensorDebounced high E6..E13,
    //    so pc only reaches 8 at E14 and the FSM falls back at E15. This is
    //    the longest presence that still produces no request.
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(6);
    checkOutput("short_deb_rise", {15'd0, sensorDebounced}, 16'd1);
    tick(2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(5);
    checkOutput("short_deb_e13", {15'd0, sensorDebounced}, 16'd1);
    tick(1);
    checkOutput("short_deb_e14", {15'd0, sensorDebounced}, 16'd0);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      checkOutput("short_req", {15'd0, vehicleRequest}, 16'd0);
    end
`ifdef SENSOR_STATS_EN
    checkOutput("short_count", vehicleCount, 16'd0);
`endif

    // 4. Full request: debounced rises at E6, request at E15.
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(6);
    checkOutput("full_deb_e6", {15'd0, sensorDebounced}, 16'd1);
    tick(8);
    checkOutput("full_req_e14", {15'd0, vehicleRequest}, 16'd0);
    tick(1);
    checkOutput("full_req_e15", {15'd0, vehicleRequest}, 16'd1);
`ifdef SENSOR_STATS_EN
    checkOutput("full_count", vehicleCount, 16'd1);
`endif
    // Sensor drops; the request must stay held.
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(10);
    checkOutput("sticky_deb", {15'd0, sensorDebounced}, 16'd0);
    checkOutput("sticky_req", {15'd0, vehicleRequest}, 16'd1);
    // Vehicle returns while still in REQUEST.
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(8);
    checkOutput("back_deb", {15'd0, sensorDebounced}, 16'd1);
    checkOutput("back_req", {15'd0, vehicleRequest}, 16'd1);
    // Grant: request drops on the next edge and stays low during green.
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick(1);
    checkOutput("grant_req", {15'd0, vehicleRequest}, 16'd0);
    tick(3);
    checkOutput("green_hold_req", {15'd0, vehicleRequest}, 16'd0);

    // 5. Requalify: green ends with the vehicle still present.
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      checkOutput("requal_req_low", {15'd0, vehicleRequest}, 16'd0);
    end
    tick(1);
    checkOutput("requal_req_e9", {15'd0, vehicleRequest}, 16'd1);
`ifdef SENSOR_STATS_EN
    checkOutput("requal_count", vehicleCount, 16'd2);
`endif

    // 6. Reset while requesting clears everything on the next edge.
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(1);
    checkOutput("midrst_req", {15'd0, vehicleRequest}, 16'd0);
    checkOutput("midrst_deb", {15'd0, sensorDebounced}, 16'd0);
`ifdef SENSOR_STATS_EN
    checkOutput("midrst_count", vehicleCount, 16'd0);
`endif
    // Back in IDLE: with green held high, full qualification is needed
    // again, then REQUEST lasts one cycle before SERVED.
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick(6);
    checkOutput("pulse_deb_e6", {15'd0, sensorDebounced}, 16'd1);
    tick(8);
    checkOutput("pulse_req_e14", {15'd0, vehicleRequest}, 16'd0);
    tick(1);
    checkOutput("pulse_req_e15", {15'd0, vehicleRequest}, 16'd1);
    tick(1);
    checkOutput("pulse_req_e16", {15'd0, vehicleRequest}, 16'd0);
`ifdef SENSOR_STATS_EN
    checkOutput("pulse_count", vehicleCount, 16'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
